// File: rtl/neq_arb_pkg.sv
// Shared definitions for the neq_compare_arbiter slice: state encoding and widths.
package neq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CMP_W  = 5;
  localparam int STAT_W = 16;

endpackage

// File: rtl/neq_cmp5.sv
// Shared 5-bit inequality comparator: bitwise XOR of the operands, OR-reduced.
module neq_cmp5 import neq_arb_pkg::*; (
  input  logic [CMP_W-1:0] a,
  input  logic [CMP_W-1:0] b,
  output logic             neq
);

  assign neq = |(a ^ b);

endmodule

// File: rtl/neq_compare_arbiter.sv
// Round-robin arbiter sharing one neq_cmp5 among N requesters (IDLE -> CMP -> RESP).
// Optional statistics counters are built when NEQ_ARB_STATS_EN is defined.
module neq_compare_arbiter import neq_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   ack,
  output logic           res_valid,
  output logic           res_neq,
  output logic [2:0]     res_id
`ifdef NEQ_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] cmp_count,
  output logic [STAT_W-1:0] neq_count
`endif
);

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       cur_id;
  logic [CMP_W-1:0] op_a;
  logic [CMP_W-1:0] op_b;
  logic             res_neq_r;
  logic             cmp_neq;
  logic [2:0]       grant_id;

  // Search runs downwards so the requester closest to the pointer is the last to overwrite.
  function automatic logic [2:0] rr_pick(input logic [N-1:0] r, input logic [2:0] p);
    logic [2:0] pick;
    int         idx;
    pick = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N;
      if (r[idx]) begin
        pick = 3'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign grant_id = rr_pick(req, ptr);

  neq_cmp5 u_cmp (
    .a   (op_a),
    .b   (op_b),
    .neq (cmp_neq)
  );

  // Transaction FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cur_id    <= 3'd0;
      op_a      <= '0;
      op_b      <= '0;
      res_neq_r <= 1'b0;
      ack       <= '0;
      res_valid <= 1'b0;
      res_neq   <= 1'b0;
      res_id    <= 3'd0;
    end else begin
      ack       <= '0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            op_a   <= a_in[int'(grant_id)*W +: CMP_W];
            op_b   <= b_in[int'(grant_id)*W +: CMP_W];
            cur_id <= grant_id;
            state  <= CMP;
          end else begin
            state  <= IDLE;
          end
        end
        CMP: begin
          res_neq_r <= cmp_neq;
          state     <= RESP;
        end
        RESP: begin
          ack       <= {{(N-1){1'b0}}, 1'b1} << cur_id;
          res_valid <= 1'b1;
          res_neq   <= res_neq_r;
          res_id    <= cur_id;
          ptr       <= (cur_id == 3'(N - 1)) ? 3'd0 : cur_id + 3'd1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NEQ_ARB_STATS_EN
  // Saturating completion counters, bumped in the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_count <= '0;
      neq_count <= '0;
    end else if (state == RESP) begin
      if (cmp_count != {STAT_W{1'b1}}) begin
        cmp_count <= cmp_count + 16'd1;
      end
      if (res_neq_r && (neq_count != {STAT_W{1'b1}})) begin
        neq_count <= neq_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_neq_compare_arbiter.sv
// Self-checking bench for neq_compare_arbiter: transaction-level model plus directed vectors.
module tb_neq_compare_arbiter;
  import neq_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   ack;
  logic           res_valid;
  logic           res_neq;
  logic [2:0]     res_id;
`ifdef NEQ_ARB_STATS_EN
  logic [15:0]    cmp_count;
  logic [15:0]    neq_count;
`endif

  int checks = 0;
  int errors = 0;

  neq_compare_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .ack       (ack),
    .res_valid (res_valid),
    .res_neq   (res_neq),
    .res_id    (res_id)
`ifdef NEQ_ARB_STATS_EN
    ,
    .cmp_count (cmp_count),
    .neq_count (neq_count)
`endif
  );

  always #5 clk = ~clk;

  // Transaction model: a grant is possible every 3 edges, the result shows after grant edge + 2.
  int m_cyc    = 0;
  int m_free   = 0;
  int m_ack_at = -1;
  int m_ptr    = 0;
  int m_id     = 0;
  bit m_neq    = 1'b0;
  int m_cmp    = 0;
  int m_neqc   = 0;

  function automatic int first_req(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    w = first_req(req, m_ptr);
    m_cyc <= m_cyc + 1;
    if (!rst_n) begin
      m_free <= 0; m_ack_at <= -1; m_ptr <= 0; m_cmp <= 0; m_neqc <= 0;
    end else begin
      if (m_cyc >= m_free && w >= 0) begin
        m_free   <= m_cyc + 3;
        m_ack_at <= m_cyc + 3;
        m_id     <= w;
        m_neq    <= (a_in[w*W +: W] != b_in[w*W +: W]);
        m_ptr    <= (w + 1) % N;
      end
      if (m_cyc + 1 == m_ack_at) begin
        m_cmp  <= (m_cmp == 65535) ? 65535 : m_cmp + 1;
        m_neqc <= (m_neq && m_neqc != 65535) ? m_neqc + 1 : m_neqc;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      bit exp_v;
      logic [N-1:0] exp_ack;
      @(posedge clk); #1;
      exp_v   = (m_cyc == m_ack_at);
      exp_ack = exp_v ? (4'b0001 << m_id) : 4'b0000;
      checks++;
      if (ack !== exp_ack || res_valid !== exp_v) begin
        errors++;
        $display("FAIL cyc_ack t=%0t: ack=%b valid=%b expected ack=%b valid=%b", $time, ack, res_valid, exp_ack, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (res_id !== 3'(m_id) || res_neq !== m_neq) begin
          errors++;
          $display("FAIL cyc_res t=%0t: id=%0d neq=%b expected id=%0d neq=%b", $time, res_id, res_neq, m_id, m_neq);
        end
      end
`ifdef NEQ_ARB_STATS_EN
      checks++;
      if (cmp_count !== 16'(m_cmp) || neq_count !== 16'(m_neqc)) begin
        errors++;
        $display("FAIL stats: cmp=%0d neq=%0d expected cmp=%0d neq=%0d", cmp_count, neq_count, m_cmp, m_neqc);
      end
`endif
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack == '0 && n < limit);
    if (ack == '0) begin
      errors++;
      $display("FAIL ack_timeout: no ack within %0d cycles", limit);
    end
  endtask

  task automatic set_ops(input int i, input logic [4:0] a, input logic [4:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  initial begin
    int n;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < N; i++) set_ops(i, 5'h1F, 5'h0F);
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_neq", int'(res_neq), 0);
    chk("rst_id", int'(res_id), 0);
    rst_n = 1'b1;

    // Fairness with all requesters held high.
    for (int k = 0; k < 5; k++) begin
      wait_ack(8, n);
      chk("rr_latency", n, 3);
      chk("rr_id", int'(res_id), exp_order[k]);
      chk("rr_neq", int'(res_neq), 1);
    end
    chk("first_ack", int'(ack), 1);
    @(negedge clk); req = 4'b0000;

    // Single requester, equal then unequal operands.
    repeat (2) @(negedge clk);
    set_ops(2, 5'h0A, 5'h0A); req = 4'b0100;
    wait_ack(8, n);
    chk("single_lat", n, 3);
    chk("single_ack", int'(ack), 4);
    chk("single_id", int'(res_id), 2);
    chk("single_eq", int'(res_neq), 0);
    @(negedge clk); set_ops(2, 5'h0A, 5'h0B);
    wait_ack(8, n);
    chk("single_neq", int'(res_neq), 1);
    @(negedge clk); req = 4'b0000;

    // Operand change during CMP must not affect the result.
    repeat (2) @(negedge clk);
    set_ops(1, 5'h03, 5'h03); req = 4'b0010;
    @(posedge clk);
    @(negedge clk); set_ops(1, 5'h04, 5'h03);
    wait_ack(8, n);
    chk("stable_lat", n, 2);
    chk("stable_id", int'(res_id), 1);
    chk("stable_neq", int'(res_neq), 0);
    @(negedge clk); req = 4'b0000;

    // Reset during CMP: no ack, pointer back to 0 so requester 1 beats 3.
    repeat (2) @(negedge clk);
    set_ops(1, 5'h01, 5'h02); set_ops(3, 5'h07, 5'h07); req = 4'b1010;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ack", int'(ack), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_ack(8, n);
    chk("post_rst_lat", n, 3);
    chk("post_rst_ack", int'(ack), 2);
    chk("post_rst_neq", int'(res_neq), 1);
    @(negedge clk); req = 4'b1000;
    wait_ack(8, n);
    chk("reserve_id", int'(res_id), 3);
    chk("reserve_neq", int'(res_neq), 0);
    @(negedge clk); req = 4'b0000;

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neq_compare_arbiter.md
# neq_compare_arbiter

Sequential arbiter that shares one 5-bit inequality comparator among N requesters. Each requester presents an operand pair with a request and receives a one-cycle acknowledge carrying the registered "a != b" result. Round-robin grant ordering guarantees fairness. The block sits between the requesting control units and the single combinational comparator instance.

## Interface
- N, default 4: number of requesters (2..8).
- W, default 5: operand width in bits; fixed at 5 for this comparator.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-requester request; held high until the matching ack.
- a_in  input  N*W  operand A; requester i occupies bits [i*W +: W].
- b_in  input  N*W  operand B; same packing as a_in.
- ack  output  N  one-hot, one-cycle pulse to the served requester.
- res_valid  output  1  high in the cycle the result is presented (same cycle as ack).
- res_neq  output  1  1 when the latched A != B, 0 when equal.
- res_id  output  3  index of the served requester.

## Operation
- FSM states:
  - IDLE: if any req bit is high, select the winner, latch its a/b into op_a/op_b, latch the index into cur_id, go to CMP. Otherwise stay in IDLE.
  - CMP: the comparator evaluates op_a/op_b; register its output into res_neq_r; go to RESP.
  - RESP: assert ack[cur_id] and res_valid; advance the round-robin pointer to cur_id+1 (mod N); go to IDLE.
- Round-robin: the search starts at the pointer and wraps through N-1 to 0. The first requester with req=1 wins. The pointer resets to 0.
- Operands are sampled only on the IDLE→CMP transition. Operand changes after that edge do not affect the result.
- A req that drops before its ack is a protocol violation. The block still completes the transaction and acks.
- A req still high in the cycle after its ack counts as a new request.
- Requests that arrive while the block is busy wait. Nothing is lost, because req is level-held.
- Output reset values: ack=0, res_valid=0, res_neq=0, res_id=0. Internal reset values: state=IDLE, pointer=0, op_a=op_b=0.
- Reset asserted mid-transaction: the block returns to IDLE immediately and the in-flight request is discarded (no ack). The requester keeps req high and is re-served after reset.

## Timing
- req is sampled high in IDLE at edge t. The operands latch at t, the result registers at t+1, and ack/res_valid/res_neq/res_id are valid for exactly the cycle after edge t+2.
- Latency from the grant edge to ack is 3 cycles. Sustained throughput is one comparison per 3 cycles.
- All outputs are registered. There is no combinational path from req, a_in or b_in to any output.
- Back-to-back: a req seen in the IDLE cycle that follows RESP starts a new transaction with no bubble beyond IDLE.

## Configuration
- NEQ_ARB_STATS_EN defined:
  - Adds two outputs: cmp_count (16 bits, total completed comparisons) and neq_count (16 bits, comparisons with res_neq=1).
  - Both counters increment in the RESP cycle, saturate at 16'hFFFF and reset to 0.
- NEQ_ARB_STATS_EN undefined: the counter logic and both ports are absent, and all other behaviour is identical.

## Structure
- Shared package neq_arb_pkg holds:
  - the state encoding: IDLE=2'd0, CMP=2'd1, RESP=2'd2;
  - the localparam CMP_W=5;
  - the localparam STAT_W=16.
- One sub-module, neq_cmp5: purely combinational, 5 XORs OR-reduced. It is instantiated once on op_a/op_b.
- The round-robin selection is a function inside the top level. It is not a separate module.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 → ack=0, res_valid=0, res_neq=0, res_id=0. After release, requester 0 is acked first, 3 cycles after the first sampling edge.
- Single request: req[2]=1, a=5'h0A, b=5'h0A → ack=4'b0100, res_id=2, res_neq=0. Then a=5'h0A, b=5'h0B → res_neq=1.
- Fairness: all four req held high continuously → ack order 0,1,2,3,0, one ack every 3 cycles. Operand pairs 5'h1F/5'h0F give res_neq=1 on every ack.
- Operand stability: change a_in for the granted requester during CMP → the result reflects the operands sampled at grant.
- Mid-transaction reset: pulse rst_n low during CMP → no ack is produced, state=IDLE, pointer=0, and the request is re-served after release.
- With NEQ_ARB_STATS_EN: 10 compares, 6 of them unequal → cmp_count=10, neq_count=6. Preload near saturation and confirm the counters hold at 16'hFFFF.
